// File: rtl/divisor_n_bits_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and counter sizing.
package divisor_n_bits_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // Iteration counter must hold the value n itself, hence n+1 codes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divisor_n_bits_sumador_restador.sv
// Combinational N-bit adder/subtractor (iOp=1 subtracts); oCout=1 on subtract means no borrow.
module sumadorRestadorNBits #(
  parameter int unsigned NBITS = 8
) (
  input  logic [NBITS-1:0] iA,
  input  logic [NBITS-1:0] iB,
  input  logic             iOp,
  output logic [NBITS-1:0] oResult,
  output logic             oCout,
  output logic             oOverflow
);

  logic [NBITS-1:0] w_b;
  logic [NBITS:0]   w_sum;

  assign w_b     = iB ^ {NBITS{iOp}};
  assign w_sum   = {1'b0, iA} + {1'b0, w_b} + (NBITS+1)'(iOp);
  assign oResult = w_sum[NBITS-1:0];
  assign oCout   = w_sum[NBITS];

  // Two's-complement overflow: same-sign operands yielding a different-sign result.
  assign oOverflow = (iA[NBITS-1] == w_b[NBITS-1]) && (oResult[NBITS-1] != iA[NBITS-1]);

endmodule

// File: rtl/divisor_n_bits.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle, start/done handshake.
module divisor_n_bits
  import divisor_n_bits_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [NBITS-1:0] iDividend,
  input  logic [NBITS-1:0] iDivisor,
  output logic [NBITS-1:0] oQuotient,
  output logic [NBITS-1:0] oRemainder,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero
);

  localparam int unsigned CW = cnt_width(NBITS);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_q;
  logic [NBITS:0]   r_r;
  logic [NBITS-1:0] r_d;
  logic [NBITS-1:0] r_quotient;
  logic [NBITS-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_div_zero;
  logic             w_last;
  logic [NBITS:0]   w_r_shift;
  logic [NBITS:0]   w_trial;
  logic             w_no_borrow;
  logic             w_sub_ovf_unused;
  logic [NBITS:0]   w_r_next;
  logic [NBITS-1:0] w_q_next;

  assign w_div_zero = (iDivisor == '0);
  assign w_last     = (r_cnt == CW'(1));

  // Shift {R,Q} left; R stays below D so its top bit is always zero before the shift.
  assign w_r_shift = (r_r << 1) | (NBITS+1)'(r_q[NBITS-1]);

  sumadorRestadorNBits #(
    .NBITS (NBITS + 1)
  ) u_trial_sub (
    .iA        (w_r_shift),
    .iB        ({1'b0, r_d}),
    .iOp       (1'b1),
    .oResult   (w_trial),
    .oCout     (w_no_borrow),
    .oOverflow (w_sub_ovf_unused)
  );

  assign w_r_next = w_no_borrow ? w_trial : w_r_shift;
  assign w_q_next = {r_q[NBITS-2:0], w_no_borrow};

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          w_state_next = w_div_zero ? ST_DONE : ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath, counter and result registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (iStart) begin
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= iDividend;
              r_div_zero  <= 1'b1;
            end else begin
              r_q   <= iDividend;
              r_r   <= '0;
              r_d   <= iDivisor;
              r_cnt <= CW'(NBITS);
            end
          end
        end
        ST_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[NBITS-1:0];
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oQuotient  = r_quotient;
  assign oRemainder = r_remainder;
  assign oBusy      = r_busy;
  assign oDone      = r_done;
  assign oDivZero   = r_div_zero;

endmodule
